// File: rtl/toggle_rx_pkg.sv
// Shared constants, pending-counter update codes and sizing helpers for the
// toggle-line event receiver.
package toggle_rx_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 4;
    localparam int TOT_W_DEF       = 16;

    localparam logic [CNT_W_DEF-1:0] PEND_MAX = {CNT_W_DEF{1'b1}};

    // {det, pop} pair selecting how the pending counter moves this edge
    typedef enum logic [1:0] {
        PEND_HOLD = 2'b00,
        PEND_POP  = 2'b01,
        PEND_DET  = 2'b10,
        PEND_BOTH = 2'b11
    } pend_op_e;

    // Warmup counter must be able to hold SYNC_STAGES, which is its terminal value
    function automatic int warm_w(input int stages);
        return $clog2(stages + 2);
    endfunction

endpackage

// File: rtl/toggle_event_receiver_sync_chain.sv
// Plain shift-register synchroniser for a single asynchronous bit; all
// stages clear on synchronous reset.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the synchroniser stages
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/toggle_event_receiver.sv
// Receiver for a toggle-encoded event line: every level change on t_in is one
// event, queued in a saturating counter and handed out over valid/ready.
module toggle_event_receiver
    import toggle_rx_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TOT_W       = TOT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_in,
    input  logic             ev_ready,
    input  logic             clr_ovf,
    output logic             ev_valid,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             level,
    output logic [TOT_W-1:0] total_events
);

    localparam int               WARM_W    = warm_w(SYNC_STAGES);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES);
    localparam logic [WARM_W-1:0] WARM_ONE  = {{(WARM_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PEND_LIM  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PEND_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TOT_W-1:0] TOT_ONE   = {{(TOT_W-1){1'b0}}, 1'b1};

    logic              w_sync;
    logic              w_det;
    logic              w_pop;
    logic              w_ovf_set;
    logic [CNT_W-1:0]  w_pend_nxt;
    pend_op_e          w_op;

    logic [WARM_W-1:0] r_warm;
    logic              r_armed;
    logic              r_prev;
    logic [CNT_W-1:0]  r_pending;
    logic              r_valid;
    logic              r_overflow;
    logic [TOT_W-1:0]  r_total;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (t_in),
        .q     (w_sync)
    );

    // Edge detect is suppressed until the synchroniser has flushed its reset zeros
    assign w_det = r_armed & (w_sync != r_prev);
    assign w_pop = r_valid & ev_ready;
    assign w_op  = pend_op_e'({w_det, w_pop});

    // Next pending count; a detection at saturation is lost and flags overflow
    always_comb begin
        w_pend_nxt = r_pending;
        w_ovf_set  = 1'b0;
        case (w_op)
            PEND_DET: begin
                if (r_pending == PEND_LIM) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_pend_nxt = r_pending + PEND_ONE;
                end
            end
            PEND_POP: begin
                w_pend_nxt = r_pending - PEND_ONE;
            end
            PEND_BOTH: begin
                w_pend_nxt = r_pending;
            end
            default: begin
                w_pend_nxt = r_pending;
            end
        endcase
    end

    // Warmup, edge history, event queue, overflow flag and running total
    always_ff @(posedge clk) begin
        if (reset) begin
            r_warm     <= '0;
            r_armed    <= 1'b0;
            r_prev     <= 1'b0;
            r_pending  <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_total    <= '0;
        end else begin
            if (!r_armed) begin
                if (r_warm == WARM_LAST) begin
                    r_armed <= 1'b1;
                end else begin
                    r_warm <= r_warm + WARM_ONE;
                end
            end
            r_prev    <= w_sync;
            r_pending <= w_pend_nxt;
            r_valid   <= (w_pend_nxt != '0);
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
            if (w_det) begin
                r_total <= r_total + TOT_ONE;
            end
        end
    end

    assign ev_valid     = r_valid;
    assign pending      = r_pending;
    assign overflow     = r_overflow;
    assign level        = w_sync;
    assign total_events = r_total;

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Directed bench: a default receiver (CNT_W=4) and a narrow one (CNT_W=2)
// share all stimulus; expected values are hand-computed per step.
module tb_toggle_event_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        t_in;
    logic        ev_ready;
    logic        clr_ovf;

    logic        ev_valid,  ev_valid2;
    logic [3:0]  pending;
    logic [1:0]  pending2;
    logic        overflow,  overflow2;
    logic        level,     level2;
    logic [15:0] total,     total2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    toggle_event_receiver #(.SYNC_STAGES(2), .CNT_W(4), .TOT_W(16)) dut (
        .clk(clk), .reset(reset), .t_in(t_in), .ev_ready(ev_ready), .clr_ovf(clr_ovf),
        .ev_valid(ev_valid), .pending(pending), .overflow(overflow),
        .level(level), .total_events(total)
    );

    toggle_event_receiver #(.SYNC_STAGES(2), .CNT_W(2), .TOT_W(16)) dut2 (
        .clk(clk), .reset(reset), .t_in(t_in), .ev_ready(ev_ready), .clr_ovf(clr_ovf),
        .ev_valid(ev_valid2), .pending(pending2), .overflow(overflow2),
        .level(level2), .total_events(total2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; t_in = 1'b1; ev_ready = 1'b0; clr_ovf = 1'b0;

        // 1: static high line through reset and warmup gives no event
        step();
        check("rst_level",   32'(level),    32'd0);
        check("rst_pending", 32'(pending),  32'd0);
        check("rst_valid",   32'(ev_valid), 32'd0);
        step();
        reset = 1'b0;
        repeat (10) step();
        check("t1_valid", 32'(ev_valid), 32'd0);
        check("t1_total", 32'(total),    32'd0);
        check("t1_level", 32'(level),    32'd1);
        check("t1_pend",  32'(pending),  32'd0);

        // 2: three toggles, ready low; first event visible two edges after sampling
        t_in = 1'b0;
        step();
        check("t2_lat_k",   32'(ev_valid), 32'd0);
        step();
        check("t2_lat_k1",  32'(ev_valid), 32'd0);
        check("t2_lvl_k1",  32'(level),    32'd0);
        step();
        check("t2_lat_k2",  32'(ev_valid), 32'd1);
        check("t2_pend_k2", 32'(pending),  32'd1);
        step();
        for (int i = 0; i < 2; i++) begin
            t_in = ~t_in;
            repeat (4) step();
        end
        check("t2_pend",  32'(pending), 32'd3);
        check("t2_total", 32'(total),   32'd3);

        // 3: drain with ready held high
        ev_ready = 1'b1;
        step();
        check("t3_pend2", 32'(pending), 32'd2);
        check("t3_val2",  32'(ev_valid), 32'd1);
        step();
        check("t3_pend1", 32'(pending), 32'd1);
        step();
        check("t3_pend0", 32'(pending), 32'd0);
        check("t3_val0",  32'(ev_valid), 32'd0);
        step();
        check("t3_idle_ready", 32'(pending), 32'd0);
        ev_ready = 1'b0;

        // 4: detection coinciding with a pop at pending=1
        t_in = 1'b1;
        repeat (4) step();
        check("t4_pre_pend",  32'(pending), 32'd1);
        check("t4_pre_total", 32'(total),   32'd4);
        t_in = 1'b0;
        step();
        step();
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        check("t4_pend",  32'(pending), 32'd1);
        check("t4_total", 32'(total),   32'd5);
        step();
        check("t4_hold",  32'(pending), 32'd1);

        // 5: saturation on the 2-bit instance
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (5) step();
        check("t5_rst_total2", 32'(total2), 32'd0);
        for (int i = 0; i < 5; i++) begin
            t_in = ~t_in;
            repeat (4) step();
        end
        check("t5_pend2",  32'(pending2),  32'd3);
        check("t5_ovf2",   32'(overflow2), 32'd1);
        check("t5_total2", 32'(total2),    32'd5);
        check("t5_pend",   32'(pending),   32'd5);
        check("t5_ovf",    32'(overflow),  32'd0);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("t5_clr_ovf2",  32'(overflow2), 32'd0);
        check("t5_clr_pend2", 32'(pending2),  32'd3);
        // new overflow in the same cycle as clear: set wins
        t_in = ~t_in;
        step();
        step();
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("t5_setwins", 32'(overflow2), 32'd1);
        check("t5_total6",  32'(total2),    32'd6);
        check("t5_pend6",   32'(pending),   32'd6);

        // 6: reset mid-queue with t_in going high, then warmup gating
        reset = 1'b1;
        t_in  = 1'b1;
        step();
        check("t6_valid", 32'(ev_valid),  32'd0);
        check("t6_pend",  32'(pending),   32'd0);
        check("t6_ovf2",  32'(overflow2), 32'd0);
        check("t6_total", 32'(total),     32'd0);
        check("t6_level", 32'(level),     32'd0);
        reset = 1'b0;
        repeat (6) step();
        check("t6_warm_total", 32'(total),   32'd0);
        check("t6_warm_pend",  32'(pending), 32'd0);
        check("t6_warm_level", 32'(level),   32'd1);
        t_in = 1'b0;
        repeat (4) step();
        check("t6_post_total", 32'(total),    32'd1);
        check("t6_post_pend",  32'(pending),  32'd1);
        check("t6_post_valid", 32'(ev_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
